// File: rtl/fast_advance_multi_if.sv
// Button/pulse bundle between the debounced key inputs, the repeat controller
// and the time-field counters.
interface fast_advance_multi_if #(
  parameter int CHANNELS = 2
);
  logic                enable;
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] hold;
  logic [CHANNELS-1:0] fast;

  modport master (output enable, in, input out, hold, fast);
  modport slave  (input enable, in, output out, hold, fast);
endinterface

// File: rtl/fast_advance_multi.sv
// N-channel press-and-hold auto-repeat controller with a slow-then-fast repeat
// rate and single-owner arbitration (lowest index wins ties).
//
// state  | meaning
// IDLE   | key released, or held since before reset/enable (waits for re-press)
// PRESS  | owner, first pulse issued, counting towards LONG
// SLOW   | owner, repeating every PERIOD_SLOW cycles
// FAST   | owner, repeating every PERIOD_FAST cycles
// LOCKED | pressed while another channel owned; silent until released
module fast_advance_multi #(
  parameter int CHANNELS     = 2,
  parameter int LONG         = 50_000_000,
  parameter int PERIOD_SLOW  = 5_000_000,
  parameter int PERIOD_FAST  = 1_250_000,
  parameter int ACCEL_PULSES = 10
) (
  input logic                 clk,
  input logic                 reset_n,
  fast_advance_multi_if.slave bus
);

  localparam int TMAX_A = (LONG - 2 > PERIOD_SLOW - 1) ? LONG - 2 : PERIOD_SLOW - 1;
  localparam int TMAX_B = (TMAX_A > PERIOD_FAST - 1) ? TMAX_A : PERIOD_FAST - 1;
  localparam int TMAX   = (TMAX_B > 1) ? TMAX_B : 1;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int AW     = (ACCEL_PULSES > 1) ? $clog2(ACCEL_PULSES) : 1;

  localparam logic [TW-1:0] LOAD_LONG = TW'(LONG - 2);
  localparam logic [TW-1:0] LOAD_SLOW = TW'(PERIOD_SLOW - 1);
  localparam logic [TW-1:0] LOAD_FAST = TW'(PERIOD_FAST - 1);
  localparam logic [AW-1:0] LOAD_ACC  = AW'(ACCEL_PULSES - 1);

  typedef enum logic [2:0] {IDLE, PRESS, SLOW, FAST, LOCKED} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [TW-1:0]       timer_q [CHANNELS];
  logic [TW-1:0]       timer_d [CHANNELS];
  logic [AW-1:0]       accel_q [CHANNELS];
  logic [AW-1:0]       accel_d [CHANNELS];
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0] fast_q, fast_d;
  logic [CHANNELS-1:0] press_edge;
  logic                taken;

  assign press_edge = bus.in & ~prev_q;
  assign bus.out    = out_q;
  assign bus.hold   = hold_q;
  assign bus.fast   = fast_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '1;
      out_q  <= '0;
      hold_q <= '0;
      fast_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
        accel_q[i] <= '0;
      end
    end else begin
      prev_q <= bus.in;
      out_q  <= out_d;
      hold_q <= hold_d;
      fast_q <= fast_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        accel_q[i] <= accel_d[i];
      end
    end
  end

  always_comb begin
    out_d  = '0;
    hold_d = '0;
    fast_d = '0;
    taken  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      accel_d[i] = accel_q[i];
    end

    // An owner that is releasing this cycle frees ownership immediately.
    for (int i = 0; i < CHANNELS; i++) begin
      if ((state_q[i] == PRESS || state_q[i] == SLOW || state_q[i] == FAST) && bus.in[i])
        taken = 1'b1;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      if (!bus.enable || !bus.in[i]) begin
        state_d[i] = IDLE;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (press_edge[i]) begin
              if (!taken) begin
                taken      = 1'b1;
                state_d[i] = PRESS;
                timer_d[i] = LOAD_LONG;
                out_d[i]   = 1'b1;
              end else begin
                state_d[i] = LOCKED;
              end
            end
          end
          PRESS: begin
            if (timer_q[i] == '0) begin
              state_d[i] = SLOW;
              timer_d[i] = LOAD_SLOW;
              accel_d[i] = LOAD_ACC;
              out_d[i]   = 1'b1;
            end else begin
              timer_d[i] = timer_q[i] - TW'(1);
            end
          end
          SLOW: begin
            if (timer_q[i] == '0) begin
              out_d[i] = 1'b1;
              if (accel_q[i] == '0) begin
                state_d[i] = FAST;
                timer_d[i] = LOAD_FAST;
              end else begin
                timer_d[i] = LOAD_SLOW;
                accel_d[i] = accel_q[i] - AW'(1);
              end
            end else begin
              timer_d[i] = timer_q[i] - TW'(1);
            end
          end
          FAST: begin
            if (timer_q[i] == '0) begin
              out_d[i]   = 1'b1;
              timer_d[i] = LOAD_FAST;
            end else begin
              timer_d[i] = timer_q[i] - TW'(1);
            end
          end
          LOCKED:  state_d[i] = LOCKED;
          default: state_d[i] = IDLE;
        endcase
      end
      hold_d[i] = (state_d[i] == SLOW) || (state_d[i] == FAST);
      fast_d[i] = (state_d[i] == FAST);
    end
  end

endmodule

// File: tb/tb_fast_advance_multi.sv
// Directed bench for fast_advance_multi: main instance with the small test
// parameters, plus a 4-channel instance with degenerate periods.
module tb_fast_advance_multi;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fast_advance_multi_if #(.CHANNELS(2)) bus0 ();
  fast_advance_multi_if #(.CHANNELS(4)) bus1 ();

  fast_advance_multi #(
    .CHANNELS(2), .LONG(8), .PERIOD_SLOW(4), .PERIOD_FAST(2), .ACCEL_PULSES(3)
  ) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  fast_advance_multi #(
    .CHANNELS(4), .LONG(3), .PERIOD_SLOW(1), .PERIOD_FAST(1), .ACCEL_PULSES(1)
  ) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus0.in = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Expected out[0] after edge h for the long-hold scenario.
  function automatic logic long_pulse(input int h);
    if (h == 1 || h == 8) return 1'b1;
    if (h > 8 && h <= 20) return ((h - 8) % 4) == 0;
    if (h > 20) return ((h - 20) % 2) == 0;
    return 1'b0;
  endfunction

  task automatic test_reset();
    bus0.enable = 1'b1; bus0.in = '0;
    bus1.enable = 1'b1; bus1.in = '0;
    #3;
    n_tests++;
    if ({bus0.out, bus0.hold, bus0.fast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {bus0.out, bus0.hold, bus0.fast});
    end
    #4 reset_n = 1'b1;
    tick(); tick();
    n_tests++;
    if ({bus0.out, bus0.hold, bus0.fast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 000000", {bus0.out, bus0.hold, bus0.fast});
    end
  endtask

  task automatic test_short_press();
    for (int h = 1; h <= 3; h++) begin
      bus0.in = 2'b01;
      tick();
      n_tests++;
      if (bus0.out !== ((h == 1) ? 2'b01 : 2'b00) || bus0.hold !== 2'b00 || bus0.fast !== 2'b00) begin
        n_fail++;
        $display("FAIL short_press h=%0d: out=%b hold=%b fast=%b expected out=%b hold=00 fast=00",
                 h, bus0.out, bus0.hold, bus0.fast, (h == 1) ? 2'b01 : 2'b00);
      end
    end
    bus0.in = 2'b00;
    tick();
    n_tests++;
    if (bus0.out !== 2'b00) begin
      n_fail++;
      $display("FAIL short_release: out=%b expected 00", bus0.out);
    end
    idle(3);
  endtask

  task automatic test_long_hold();
    for (int h = 1; h <= 30; h++) begin
      bus0.in = 2'b01;
      tick();
      n_tests++;
      if (bus0.out !== {1'b0, long_pulse(h)} || bus0.hold !== {1'b0, h >= 8} ||
          bus0.fast !== {1'b0, h >= 20}) begin
        n_fail++;
        $display("FAIL long_hold h=%0d: out=%b hold=%b fast=%b expected out=%b hold=%b fast=%b",
                 h, bus0.out, bus0.hold, bus0.fast, {1'b0, long_pulse(h)}, {1'b0, h >= 8},
                 {1'b0, h >= 20});
      end
    end
    bus0.in = 2'b00;
    tick();
    n_tests++;
    if ({bus0.out, bus0.hold, bus0.fast} !== 6'b0) begin
      n_fail++;
      $display("FAIL long_release: out/hold/fast=%b expected 000000", {bus0.out, bus0.hold, bus0.fast});
    end
    idle(3);
  endtask

  task automatic test_tie_lock();
    for (int h = 1; h <= 5; h++) begin
      bus0.in = 2'b11;
      tick();
      n_tests++;
      if (bus0.out !== ((h == 1) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL tie h=%0d: out=%b expected %b", h, bus0.out, (h == 1) ? 2'b01 : 2'b00);
      end
    end
    for (int k = 0; k < 12; k++) begin
      bus0.in = 2'b10;
      tick();
      n_tests++;
      if (bus0.out !== 2'b00 || bus0.hold !== 2'b00) begin
        n_fail++;
        $display("FAIL locked k=%0d: out=%b hold=%b expected 00 00", k, bus0.out, bus0.hold);
      end
    end
    bus0.in = 2'b00;
    tick();
    bus0.in = 2'b10;
    tick();
    n_tests++;
    if (bus0.out !== 2'b10) begin
      n_fail++;
      $display("FAIL repress_ch1: out=%b expected 10", bus0.out);
    end
    idle(3);
  endtask

  task automatic test_enable();
    for (int h = 1; h <= 20; h++) begin
      bus0.in = 2'b10;
      tick();
    end
    n_tests++;
    if (bus0.out !== 2'b10 || bus0.fast !== 2'b10 || bus0.hold !== 2'b10) begin
      n_fail++;
      $display("FAIL enable_pre_fast: out=%b hold=%b fast=%b expected 10 10 10",
               bus0.out, bus0.hold, bus0.fast);
    end
    bus0.enable = 1'b0;
    tick();
    n_tests++;
    if ({bus0.out, bus0.hold, bus0.fast} !== 6'b0) begin
      n_fail++;
      $display("FAIL enable_drop: out/hold/fast=%b expected 000000", {bus0.out, bus0.hold, bus0.fast});
    end
    bus0.enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if (bus0.out !== 2'b00 || bus0.hold !== 2'b00) begin
        n_fail++;
        $display("FAIL enable_held k=%0d: out=%b hold=%b expected 00 00", k, bus0.out, bus0.hold);
      end
    end
    bus0.in = 2'b00;
    tick();
    bus0.in = 2'b10;
    tick();
    n_tests++;
    if (bus0.out !== 2'b10) begin
      n_fail++;
      $display("FAIL enable_repress: out=%b expected 10", bus0.out);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_fast();
    for (int h = 1; h <= 21; h++) begin
      bus0.in = 2'b01;
      tick();
    end
    n_tests++;
    if (bus0.fast !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset_fast: fast=%b expected 01", bus0.fast);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus0.out, bus0.hold, bus0.fast} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset: out/hold/fast=%b expected 000000", {bus0.out, bus0.hold, bus0.fast});
    end
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_tests++;
      if (bus0.out !== 2'b00 || bus0.hold !== 2'b00) begin
        n_fail++;
        $display("FAIL held_through_reset k=%0d: out=%b hold=%b expected 00 00", k, bus0.out, bus0.hold);
      end
    end
    bus0.in = 2'b00;
    tick();
    bus0.in = 2'b01;
    tick();
    n_tests++;
    if (bus0.out !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_repress: out=%b expected 01", bus0.out);
    end
    idle(3);
  endtask

  task automatic test_param_sweep();
    logic exp_out;
    for (int h = 1; h <= 10; h++) begin
      bus1.in = 4'b1000;
      tick();
      exp_out = (h == 1) || (h >= 3);
      n_tests++;
      if (bus1.out !== {exp_out, 3'b000} || bus1.hold !== {h >= 3, 3'b000} ||
          bus1.fast !== {h >= 4, 3'b000}) begin
        n_fail++;
        $display("FAIL sweep h=%0d: out=%b hold=%b fast=%b expected out=%b hold=%b fast=%b",
                 h, bus1.out, bus1.hold, bus1.fast, {exp_out, 3'b000}, {h >= 3, 3'b000},
                 {h >= 4, 3'b000});
      end
    end
    bus1.in = 4'b0000;
    tick();
    n_tests++;
    if ({bus1.out, bus1.hold, bus1.fast} !== 12'b0) begin
      n_fail++;
      $display("FAIL sweep_release: out/hold/fast=%b expected 0", {bus1.out, bus1.hold, bus1.fast});
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_tie_lock();
    test_enable();
    test_reset_mid_fast();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
